// File: rtl/mio_map_pkg.sv
// Shared address map, ASCII constants and controller state type for the MIO text console master.
package mio_map_pkg;

    localparam logic [31:0] VRAM_BASE       = 32'hC000_0000;
    localparam logic [31:0] CURSOR_ROW_ADDR = 32'h0000_1000;
    localparam logic [31:0] CURSOR_COL_ADDR = 32'h0000_1001;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] SP = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CHAR,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_SCR_CLR,
        ST_CUR_ROW,
        ST_CUR_COL
    } console_state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column counters for the text console; flags when an advance would run past the last row.
module console_cursor #(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             newline,
    input  logic             backspace,
    input  logic             clamp,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             ovf_on_inc,
    output logic             ovf_on_newline
);

    logic             last_col;
    logic             last_row;
    logic [ROW_W-1:0] row_adv;

    assign last_col       = (col == COL_W'(COLS - 1));
    assign last_row       = (row == ROW_W'(ROWS - 1));
    assign ovf_on_newline = last_row;
    assign ovf_on_inc     = last_row & last_col;

    // On overflow the row either stays on the last line (a scroll follows) or wraps to the top.
    always_comb begin
        row_adv = row + ROW_W'(1);
        if (last_row) begin
            row_adv = clamp ? ROW_W'(ROWS - 1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (newline) begin
            row <= row_adv;
            col <= '0;
        end else if (inc) begin
            if (last_col) begin
                row <= row_adv;
                col <= '0;
            end else begin
                col <= col + COL_W'(1);
            end
        end else if (backspace && (col != '0)) begin
            col <= col - COL_W'(1);
        end
    end

endmodule

// File: rtl/mio_console_master.sv
// MIO bus initiator converting an ASCII byte stream into VRAM glyph and cursor register writes.
// Screen scrolling through VRAM read/write copies is included when CONSOLE_SCROLL_EN is defined.
module mio_console_master
    import mio_map_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] mem_a,
    output logic [31:0] d_t_mem,
    input  logic [31:0] d_f_mem,
    output logic        wmem,
    output logic        rmem,
    output logic        busy
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    console_state_t   state;
    console_state_t   state_next;
    logic [6:0]       char_q;
    logic             adv_q;
    logic             cur_inc;
    logic             cur_nl;
    logic             cur_bs;
    logic             cur_clamp;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             ovf_on_inc;
    logic             ovf_on_newline;
    logic             scroll_on_inc;
    logic             scroll_on_nl;
    logic             wr_pend;
    logic             rd_pend;
    logic [31:0]      cell_addr;

`ifdef CONSOLE_SCROLL_EN
    localparam int IDX_W = $clog2(ROWS * COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS * COLS - 1);

    logic [IDX_W-1:0] scr_idx;
    logic [6:0]       scr_data;
    logic             unused_rdata;

    assign cur_clamp     = 1'b1;
    assign scroll_on_inc = ovf_on_inc;
    assign scroll_on_nl  = ovf_on_newline;
    assign unused_rdata  = ^d_f_mem[31:7];
`else
    logic unused_sig;

    assign cur_clamp     = 1'b0;
    assign scroll_on_inc = 1'b0;
    assign scroll_on_nl  = 1'b0;
    assign unused_sig    = ^{d_f_mem, ovf_on_inc, ovf_on_newline};
`endif

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc            (cur_inc),
        .newline        (cur_nl),
        .backspace      (cur_bs),
        .clamp          (cur_clamp),
        .row            (row),
        .col            (col),
        .ovf_on_inc     (ovf_on_inc),
        .ovf_on_newline (ovf_on_newline)
    );

    assign cell_addr = VRAM_BASE + 32'(row) * 32'(COLS) + 32'(col);
    assign wmem      = wr_pend & bus_gnt;
    assign rmem      = rd_pend & bus_gnt;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Backspace reuses the glyph write path with a blank and no cursor advance afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_q <= '0;
            adv_q  <= 1'b0;
        end else if ((state == ST_IDLE) && ch_valid) begin
            char_q <= (ch_data == BS) ? SP[6:0] : ch_data[6:0];
            adv_q  <= (ch_data != BS);
        end
    end

`ifdef CONSOLE_SCROLL_EN
    // One index walks the copy sources, then carries on through the last row for the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_idx  <= '0;
            scr_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_WR_CHAR: scr_idx <= IDX_W'(COLS);
                ST_SCR_RD: begin
                    if (bus_gnt) begin
                        scr_data <= d_f_mem[6:0];
                    end
                end
                ST_SCR_WR: begin
                    if (bus_gnt) begin
                        scr_idx <= (scr_idx == LAST_IDX) ? IDX_W'((ROWS - 1) * COLS)
                                                         : scr_idx + IDX_W'(1);
                    end
                end
                ST_SCR_CLR: begin
                    if (bus_gnt) begin
                        scr_idx <= scr_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
`endif

    always_comb begin
        state_next = state;
        ch_ready   = 1'b0;
        bus_req    = 1'b1;
        mem_a      = '0;
        d_t_mem    = '0;
        wr_pend    = 1'b0;
        rd_pend    = 1'b0;
        cur_inc    = 1'b0;
        cur_nl     = 1'b0;
        cur_bs     = 1'b0;
        case (state)
            ST_IDLE: begin
                ch_ready = 1'b1;
                bus_req  = 1'b0;
                if (ch_valid) begin
                    if (is_printable(ch_data)) begin
                        state_next = ST_WR_CHAR;
                    end else if (ch_data == LF) begin
                        cur_nl     = 1'b1;
                        state_next = scroll_on_nl ? ST_SCR_RD : ST_CUR_ROW;
                    end else if ((ch_data == BS) && (col != '0)) begin
                        cur_bs     = 1'b1;
                        state_next = ST_WR_CHAR;
                    end
                end
            end
            ST_WR_CHAR: begin
                mem_a   = cell_addr;
                d_t_mem = {25'h0, char_q};
                wr_pend = 1'b1;
                if (bus_gnt) begin
                    cur_inc    = adv_q;
                    state_next = (adv_q && scroll_on_inc) ? ST_SCR_RD : ST_CUR_ROW;
                end
            end
`ifdef CONSOLE_SCROLL_EN
            ST_SCR_RD: begin
                mem_a   = VRAM_BASE + 32'(scr_idx);
                rd_pend = 1'b1;
                if (bus_gnt) begin
                    state_next = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                mem_a   = VRAM_BASE + 32'(scr_idx) - 32'(COLS);
                d_t_mem = {25'h0, scr_data};
                wr_pend = 1'b1;
                if (bus_gnt) begin
                    state_next = (scr_idx == LAST_IDX) ? ST_SCR_CLR : ST_SCR_RD;
                end
            end
            ST_SCR_CLR: begin
                mem_a   = VRAM_BASE + 32'(scr_idx);
                d_t_mem = {24'h0, SP};
                wr_pend = 1'b1;
                if (bus_gnt && (scr_idx == LAST_IDX)) begin
                    state_next = ST_CUR_ROW;
                end
            end
`endif
            ST_CUR_ROW: begin
                mem_a   = CURSOR_ROW_ADDR;
                d_t_mem = 32'(row);
                wr_pend = 1'b1;
                if (bus_gnt) begin
                    state_next = ST_CUR_COL;
                end
            end
            ST_CUR_COL: begin
                mem_a   = CURSOR_COL_ADDR;
                d_t_mem = 32'(col);
                wr_pend = 1'b1;
                if (bus_gnt) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mio_console_master.sv
// Directed bench for mio_console_master: character vectors, wrap, stalls, scroll and mid-sequence reset.
module tb_mio_console_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ch_valid = 1'b0;
    logic [7:0]  ch_data = 8'h00;
    logic        ch_ready;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [31:0] mem_a;
    logic [31:0] d_t_mem;
    logic [31:0] d_f_mem;
    logic        wmem;
    logic        rmem;
    logic        busy;

    always #5 clk = ~clk;

    mio_console_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .mem_a    (mem_a),
        .d_t_mem  (d_t_mem),
        .d_f_mem  (d_f_mem),
        .wmem     (wmem),
        .rmem     (rmem),
        .busy     (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  ch;
        int          lat;
        int          nwr;
        logic [31:0] a [3];
        logic [31:0] d [3];
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    wr_t  wr_log [$];
    vec_t vecs [$];
    logic [7:0] vram [0:2399];
    logic [31:0] vidx;

    int   strobe_viol = 0;
    int   addr_viol = 0;
    int   stall_cnt = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic toggling = 1'b0;

    // VRAM model answering reads combinationally and absorbing granted writes.
    always_comb begin
        vidx    = mem_a - 32'hC000_0000;
        d_f_mem = '0;
        if (mem_a >= 32'hC000_0000 && vidx < 32'd2400) begin
            d_f_mem = {24'h0, vram[vidx]};
        end
    end

    always @(posedge clk) begin
        if (rst_n && wmem) begin
            wr_log.push_back('{mem_a, d_t_mem});
            if (mem_a >= 32'hC000_0000 && vidx < 32'd2400) begin
                vram[vidx] <= d_t_mem[7:0];
            end
        end
    end

    always @(negedge clk) begin
        if (busy && !bus_gnt) begin
            stall_cnt++;
            if (wmem || rmem) strobe_viol++;
        end
        if (prev_stall && busy && (mem_a != prev_addr)) addr_viol++;
        prev_stall = busy && !bus_gnt;
        prev_addr  = mem_a;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [7:0] ch, input int lat, input int nwr,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1,
                          input logic [31:0] a2, input logic [31:0] d2);
        vec_t v;
        v.ch = ch; v.lat = lat; v.nwr = nwr;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        ch_valid = 1'b0;
        bus_gnt  = 1'b1;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offers one character, then counts negedges until ch_ready returns.
    task automatic applyStimulus(input logic [7:0] c, input int limit, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!ch_ready && w < limit) begin
            @(negedge clk);
            w++;
        end
        wr_log.delete();
        ch_valid = 1'b1;
        ch_data  = c;
        @(posedge clk);
        #1 ch_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ch_ready && lat < limit);
        if (!ch_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout on char %h after %0d cycles", c, lat);
        end
    endtask

    task automatic checkWrites(input string name, input int nwr,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [31:0] d1);
        int n;
        n = wr_log.size();
        checkOutput({name, "_nwr"}, n, nwr);
        if (n >= 2) begin
            checkOutput({name, "_row_addr"}, wr_log[n-2].addr, a0);
            checkOutput({name, "_row_data"}, wr_log[n-2].data, d0);
            checkOutput({name, "_col_addr"}, wr_log[n-1].addr, a1);
            checkOutput({name, "_col_data"}, wr_log[n-1].data, d1);
        end
    endtask

    initial begin
        int lat;
        int bad;
        int n;

        for (int i = 0; i < 2400; i++) vram[i] = 8'h00;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_ch_ready", 32'(ch_ready), 32'd1);
        checkOutput("rst_bus_req",  32'(bus_req),  32'd0);
        checkOutput("rst_wmem",     32'(wmem),     32'd0);
        checkOutput("rst_rmem",     32'(rmem),     32'd0);
        checkOutput("rst_mem_a",    mem_a,         32'd0);
        checkOutput("rst_d_t_mem",  d_t_mem,       32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        doReset();

        addVec(8'h41, 4, 3, 32'hC000_0000, 32'h41, 32'h1000, 32'd0, 32'h1001, 32'd1);
        addVec(8'h42, 4, 3, 32'hC000_0001, 32'h42, 32'h1000, 32'd0, 32'h1001, 32'd2);
        addVec(8'h0A, 3, 2, 32'h1000, 32'd1, 32'h1001, 32'd0, 32'h0, 32'h0);
        addVec(8'h08, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        addVec(8'h01, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        addVec(8'h7A, 4, 3, 32'hC000_0050, 32'h7A, 32'h1000, 32'd1, 32'h1001, 32'd1);
        addVec(8'h08, 4, 3, 32'hC000_0050, 32'h20, 32'h1000, 32'd1, 32'h1001, 32'd0);
        addVec(8'h7F, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        addVec(8'hC1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        addVec(8'h7E, 4, 3, 32'hC000_0050, 32'h7E, 32'h1000, 32'd1, 32'h1001, 32'd1);
        addVec(8'h20, 4, 3, 32'hC000_0051, 32'h20, 32'h1000, 32'd1, 32'h1001, 32'd2);
        addVec(8'h0D, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ch, 20, lat);
            checkOutput($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            checkOutput($sformatf("v%0d_nwr", i), wr_log.size(), vecs[i].nwr);
            if (wr_log.size() == vecs[i].nwr) begin
                for (int k = 0; k < vecs[i].nwr; k++) begin
                    checkOutput($sformatf("v%0d_w%0d_addr", i, k), wr_log[k].addr, vecs[i].a[k]);
                    checkOutput($sformatf("v%0d_w%0d_data", i, k), wr_log[k].data, vecs[i].d[k]);
                end
            end
        end

        // A full row of glyphs wraps the cursor to the start of row 1.
        doReset();
        for (int i = 0; i < 80; i++) applyStimulus(8'h78, 20, lat);
        checkOutput("wrap_nwr", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            checkOutput("wrap_last_vram_addr", wr_log[0].addr, 32'hC000_004F);
            checkOutput("wrap_last_vram_data", wr_log[0].data, 32'h78);
        end
        checkWrites("wrap", 3, 32'h1000, 32'd1, 32'h1001, 32'd0);

        // Grant toggling every cycle must stretch the access without changing it.
        doReset();
        strobe_viol = 0;
        addr_viol   = 0;
        stall_cnt   = 0;
        toggling    = 1'b1;
        fork
            begin
                applyStimulus(8'h43, 40, lat);
                toggling = 1'b0;
            end
            begin
                while (toggling) begin
                    @(posedge clk);
                    #1 if (toggling) bus_gnt = ~bus_gnt;
                end
            end
        join
        bus_gnt = 1'b1;
        checkOutput("gnt_nwr", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            checkOutput("gnt_vram_addr", wr_log[0].addr, 32'hC000_0000);
            checkOutput("gnt_vram_data", wr_log[0].data, 32'h43);
        end
        checkWrites("gnt", 3, 32'h1000, 32'd0, 32'h1001, 32'd1);
        checkOutput("gnt_strobe_in_stall", strobe_viol, 0);
        checkOutput("gnt_addr_moved_in_stall", addr_viol, 0);
        checkOutput("gnt_stall_seen", 32'(stall_cnt > 0), 32'd1);

        // Newline on the last row against a screen whose row r holds 0x30+r.
        doReset();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) vram[r*80 + c] = 8'h30 + 8'(r);
        for (int i = 0; i < 29; i++) applyStimulus(8'h0A, 20, lat);
        applyStimulus(8'h0A, 6000, lat);
`ifdef CONSOLE_SCROLL_EN
        checkOutput("scroll_lat", lat, 4723);
        checkOutput("scroll_nwr", wr_log.size(), 2402);
        for (int r = 0; r < 30; r++) begin
            if (r == 0 || r == 1 || r == 28 || r == 29) begin
                bad = 0;
                for (int c = 0; c < 80; c++)
                    if (vram[r*80 + c] != ((r == 29) ? 8'h20 : 8'h31 + 8'(r))) bad++;
                checkOutput($sformatf("scroll_row%0d_bad_cells", r), bad, 0);
            end
        end
        n = wr_log.size();
        checkWrites("scroll_cursor", n, 32'h1000, 32'd29, 32'h1001, 32'd0);
`else
        checkOutput("wrap_row_lat", lat, 3);
        bad = 0;
        for (int c = 0; c < 80; c++) if (vram[c] != 8'h30) bad++;
        checkOutput("wrap_row0_untouched", bad, 0);
        checkWrites("wrap_row_cursor", 2, 32'h1000, 32'd0, 32'h1001, 32'd0);
`endif

        // Reset in the middle of a multi-cycle sequence drops the strobes at once.
        doReset();
        for (int i = 0; i < 29; i++) applyStimulus(8'h0A, 20, lat);
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h0A;
        @(posedge clk);
        #1 ch_valid = 1'b0;
`ifdef CONSOLE_SCROLL_EN
        repeat (100) @(negedge clk);
`else
        @(negedge clk);
`endif
        checkOutput("midrst_strobe_before", 32'(wmem | rmem), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_wmem", 32'(wmem), 32'd0);
        checkOutput("midrst_rmem", 32'(rmem), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ready", 32'(ch_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(8'h44, 20, lat);
        checkOutput("midrst_nwr", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            checkOutput("midrst_vram_addr", wr_log[0].addr, 32'hC000_0000);
            checkOutput("midrst_vram_data", wr_log[0].data, 32'h44);
        end
        checkWrites("midrst", 3, 32'h1000, 32'd0, 32'h1001, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/mio_console_master.md
# mio_console_master

Bus initiator that turns a byte stream of ASCII characters into the memory-mapped I/O bus accesses the text console needs. For each accepted character it writes the glyph into character VRAM and updates the cursor row/column registers. It optionally scrolls the screen by copying VRAM rows upward through bus reads and writes. It sits on the master side of the MIO bus, beside the CPU, behind a one-bit grant from the bus arbiter.

## Interface
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- VRAM_BASE, 32'hC000_0000, address of cell (0,0); cell address = VRAM_BASE + row*COLS + col
- CURSOR_ROW_ADDR, 32'h0000_1000, cursor row register
- CURSOR_COL_ADDR, 32'h0000_1001, cursor column register

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- ch_valid  in  1  character offered
- ch_data  in  8  ASCII character
- ch_ready  out  1  block can accept; transfer on ch_valid & ch_ready
- bus_req  out  1  block wants the bus this cycle
- bus_gnt  in  1  arbiter grant; an access completes only in a cycle with bus_gnt=1
- mem_a  out  32  access address
- d_t_mem  out  32  write data
- d_f_mem  in  32  read data, combinational from bus, valid in the same cycle as rmem
- wmem  out  1  write strobe, = pending write & bus_gnt
- rmem  out  1  read strobe, = pending read & bus_gnt
- busy  out  1  not IDLE

## Operation
- States: IDLE, WR_CHAR, SCR_RD, SCR_WR, SCR_CLR, CUR_ROW, CUR_COL.
- IDLE: ch_ready=1, bus_req=0. On accept, latch ch_data and decode it:
  - 0x20–0x7E: WR_CHAR writes {25'h0, ch[6:0]} at (row,col). Then col+1. If col reaches COLS: col=0, row+1.
  - 0x0A: col=0, row+1. No VRAM write.
  - 0x08: if col>0, col−1 and write 0x20 at the new cell. If col=0, no write and no cursor change.
  - Any other byte: dropped. Return to IDLE with no bus access.
- If row+1 == ROWS, go to the scroll sequence, then to CUR_ROW with row=ROWS−1.
- Otherwise go straight to CUR_ROW.
- Scroll sequence, for i from COLS to ROWS*COLS−1:
  - SCR_RD reads VRAM_BASE+i and captures d_f_mem[6:0] on the granted edge.
  - SCR_WR writes that value to VRAM_BASE+i−COLS.
  - SCR_CLR then writes 0x20 to the COLS cells of the last row.
- CUR_ROW writes the row to CURSOR_ROW_ADDR. CUR_COL writes the column to CURSOR_COL_ADDR. Then IDLE.
- Write data for cursor registers is zero-extended to 32 bits.
- Cursor counters are clog2(COLS) and clog2(ROWS) bits wide. The linear address is computed at 32-bit width.

## Timing
- Reset (asynchronous, immediate) gives:
  - state IDLE, row=col=0
  - ch_ready=1, bus_req=0, wmem=rmem=0, mem_a=d_t_mem=0, busy=0
- Reset mid-operation abandons the sequence. Any partially scrolled screen is left as is.
- Every non-IDLE state asserts bus_req and advances only on a rising edge with bus_gnt=1. While bus_gnt=0, mem_a and d_t_mem hold and the strobes are 0.
- Printable character, no scroll, gnt held 1: accept at edge 0, then WR_CHAR, CUR_ROW, CUR_COL in cycles 1–3. ch_ready is 1 again in cycle 4.
- Newline without scroll: ch_ready is back in cycle 3.
- Scroll adds 2*(ROWS−1)*COLS + COLS granted cycles.
- ch_ready=0 in every non-IDLE state. ch_valid is ignored there.

## Configuration
- CONSOLE_SCROLL_EN defined: scroll sequence as above.
- Not defined: SCR_* states are removed. A row overflow wraps row to 0, with no VRAM copy and no clear.

## Structure
- Package mio_map_pkg holds:
  - VRAM_BASE, CURSOR_ROW_ADDR, CURSOR_COL_ADDR
  - the state enum type
  - the ASCII constants LF=8'h0A, BS=8'h08, SP=8'h20
- Sub-module console_cursor holds the row/col counters with inc, newline, backspace and clamp-to-last-row controls. It flags row overflow.

## Test plan
- Reset, then send 'A' (0x41) with gnt=1:
  - writes: 0xC000_0000←0x41, 0x1000←0, 0x1001←1
  - ch_ready returns in cycle 4
- Send 80 × 'x':
  - last VRAM write is to 0xC000_004F
  - final cursor writes are row=1, col=0
- Send 0x08 at col 0: no bus write. Then 'B' followed by 0x08:
  - 0xC000_0000←0x20
  - col written as 0
- Toggle bus_gnt 1/0 every cycle during 'C':
  - no strobe in any gnt=0 cycle
  - mem_a is stable across stalls
  - same write sequence as with gnt=1
- With row=29, send 0x0A (CONSOLE_SCROLL_EN defined) against a VRAM model preloaded with row r = 0x30+r:
  - afterwards row 0 = 0x31, row 28 = 0x4D, row 29 = 0x20
  - cursor written (29,0)
- Assert rst_n low mid-scroll:
  - strobes drop in the same cycle
  - after release, 'D' goes to 0xC000_0000
